// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage CPU.
// It decides hold/flush for the PC and pipeline registers and supplies the
// next PC. It handles load-use stalls, branch redirects, memory waits and
// the end-of-program drain/halt sequence.
module hazard_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h00400000,
  parameter logic [31:0] END_ADDR     = 32'h00400060,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            pc_out,
  input  logic                   br_taken,
  input  logic [31:0]            br_target,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rt,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic [31:0]            pc_in,
  output logic                   pc_keep,
  output logic                   if_id_keep,
  output logic                   id_ex_keep,
  output logic                   ex_mem_keep,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   halted,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // Reject impossible parameter sets at elaboration; the drain counter is 4 bits.
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || RESET_PC >= END_ADDR) begin : g_param_err
    $error("hazard_ctrl: DRAIN_CYCLES must be 1..15 and RESET_PC below END_ADDR");
  end

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [3:0]             DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] STALL_MAX  = {STALL_CNT_W{1'b1}};

  state_e                   state_q, state_d;
  logic [3:0]               drain_cnt_q, drain_cnt_d;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                     halted_q, halted_d;
  logic                     freeze;
  logic                     lu_hazard;

  assign freeze    = mem_req & ~mem_ready;
  assign lu_hazard = ex_mem_read & (ex_rt != 5'd0) &
                     ((id_use_rs & (id_rs == ex_rt)) | (id_use_rt & (id_rt == ex_rt)));

  assign state     = state_q;
  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;

  // Per-cycle keep/flush decode and next-PC selection, in priority order.
  always_comb begin
    pc_in       = pc_out + 32'd4;
    pc_keep     = 1'b0;
    if_id_keep  = 1'b0;
    id_ex_keep  = 1'b0;
    ex_mem_keep = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (state_q == ST_HALT || freeze) begin
      pc_keep     = 1'b1;
      if_id_keep  = 1'b1;
      id_ex_keep  = 1'b1;
      ex_mem_keep = 1'b1;
    end else if (br_taken) begin
      pc_in       = br_target;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_hazard) begin
      pc_keep     = 1'b1;
      if_id_keep  = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == ST_DRAIN) begin
      pc_keep     = 1'b1;
      if_id_flush = 1'b1;
    end else begin
      pc_in = pc_out + 32'd4;
    end
  end

  // Next state, drain countdown and saturating stall count; a freeze holds the FSM.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      case (state_q)
        ST_RUN: begin
          if (pc_out >= END_ADDR && !br_taken) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (br_taken) begin
            if (br_target < END_ADDR) begin
              state_d     = ST_RUN;
              drain_cnt_d = 4'd0;
            end else begin
              drain_cnt_d = DRAIN_LOAD;
            end
          end else if (drain_cnt_q == 4'd0) begin
            state_d = ST_HALT;
          end else begin
            drain_cnt_d = drain_cnt_q - 4'd1;
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: begin
          state_d     = ST_RUN;
          drain_cnt_d = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (state_q != ST_HALT && (freeze || lu_hazard) && stall_cnt_q != STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    halted_d = (state_d == ST_HALT);
  end

  // Sequencer state registers with asynchronous reset to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 4'd0;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      halted_q    <= halted_d;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage CPU. It decides each cycle whether the PC and the pipeline registers advance, hold, or flush, and supplies the next PC value (`pc_in`) to the PC register. It handles four cases: load-use hazards, taken-branch redirects from EX, data-memory wait handshakes, and end-of-program drain and halt. It sits between the PC/IF-ID/ID-EX/EX-MEM registers and the decode/execute/memory stages.

## Interface
Parameters:
- `RESET_PC`, 32'h00400000, first instruction address (documentation only; the PC register owns the reset value)
- `END_ADDR`, 32'h00400060, first address past the program; fetch at or above it starts the drain
- `DRAIN_CYCLES`, 4, cycles needed for in-flight instructions to retire; range 1..15
- `STALL_CNT_W`, 16, width of the stall performance counter

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `pc_out`  in  32  current PC
- `br_taken`  in  1  EX stage resolved a taken branch or jump
- `br_target`  in  32  redirect address, valid with `br_taken`
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID
- `id_use_rs`, `id_use_rt`  in  1 each  ID instruction reads rs / rt
- `ex_mem_read`  in  1  instruction in EX is a load
- `ex_rt`  in  5  load destination register
- `mem_req`  in  1  MEM stage has an access outstanding
- `mem_ready`  in  1  data memory completes the access this cycle
- `pc_in`  out  32  next PC
- `pc_keep`, `if_id_keep`, `id_ex_keep`, `ex_mem_keep`  out  1 each  hold the register
- `if_id_flush`, `id_ex_flush`  out  1 each  load a bubble (NOP)
- `halted`  out  1  program finished
- `state`  out  2  RUN=0, DRAIN=1, HALT=2
- `stall_cnt`  out  STALL_CNT_W  saturating count of stall cycles

## Operation
- Define `freeze = mem_req & ~mem_ready`.
- Define `lu_hazard = ex_mem_read & (ex_rt != 0) & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt))`.
- Default outputs: `pc_in = pc_out + 4` (mod 2^32); all keeps and flushes are 0.
- Priority within a cycle, highest first:
  1. HALT state: all four keeps are 1, flushes are 0, and `halted` is 1.
  2. `freeze`: all four keeps are 1 and flushes are 0. Nothing else takes effect, including `br_taken`. The branch stays in EX and is acted on after the freeze.
  3. `br_taken`: `pc_in = br_target`, `pc_keep` is 0, and `if_id_flush` and `id_ex_flush` are both 1. Branch beats load-use because the dependent instruction is squashed.
  4. `lu_hazard`: `pc_keep` is 1, `if_id_keep` is 1, and `id_ex_flush` is 1, which gives exactly one bubble.
  5. DRAIN state with none of the above: `pc_keep` is 1 and `if_id_flush` is 1, so no fetch past `END_ADDR`.
- State machine (advances only on non-freeze cycles; freeze holds the state and the counter):
  - RUN→DRAIN when `pc_out >= END_ADDR` and `br_taken` is 0. Load `drain_cnt = DRAIN_CYCLES-1`.
  - DRAIN→RUN when `br_taken` and `br_target < END_ADDR`. `drain_cnt` is cleared.
  - DRAIN with `br_taken` and `br_target >= END_ADDR`: stay in DRAIN and reload `drain_cnt`.
  - DRAIN, no branch, `drain_cnt == 0` → HALT. Otherwise `drain_cnt` decrements by 1.
  - HALT is left only by reset.
- `stall_cnt` increments on every cycle with (`freeze` or `lu_hazard`) outside HALT. It saturates at all-ones with no wrap.

## Timing
- All decode and keep/flush outputs are combinational from the current state and inputs, valid in the same cycle.
- `state`, `drain_cnt`, `stall_cnt` and `halted` update on the rising edge of `clk`.
- Reset is asynchronous. While asserted and after release:
  - `state` = RUN, `drain_cnt` = 0, `stall_cnt` = 0, `halted` = 0.
  - Combinational outputs follow the default rules for the RUN state.
- Reset mid-freeze or mid-drain abandons the operation immediately.
- Load-use costs exactly 1 cycle: the hazard is gone once the load moves to MEM.
- A taken branch costs 2 bubbles.
- A freeze lasts until the cycle `mem_ready` is 1 inclusive. On that cycle the keeps are 0.
- Drain length is `DRAIN_CYCLES` non-frozen cycles from DRAIN entry to HALT.

## Test plan
- Load-use: `lw $8` in EX, ID uses rs=8 → 1 cycle with `pc_keep`=1, `if_id_keep`=1, `id_ex_flush`=1. The next cycle is normal. Same case with `ex_rt`=0 → no stall.
- Branch plus load-use in the same cycle with `br_target`=0x00400010 → `pc_in`=0x00400010, both flushes 1, `pc_keep`=0.
- Memory wait: `mem_req`=1 with `mem_ready` low for 3 cycles while `br_taken`=1 → all keeps 1 for 3 cycles and redirect ignored. On the cycle `mem_ready`=1, redirect is applied and `stall_cnt`=3.
- End of program: `pc_out`=0x00400060 → DRAIN. After 4 non-frozen cycles `halted`=1, `state`=2, all keeps 1. A freeze of 2 cycles inside DRAIN extends this to 6.
- Branch during DRAIN with target 0x00400020 → `state` returns to 0 and `pc_in`=0x00400020.
- Asynchronous reset pulsed mid-DRAIN between clock edges → `state`=0, `stall_cnt`=0, `halted`=0 immediately. `stall_cnt` forced near max saturates at 16'hFFFF.
